// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory with burst auto-increment. SPI edges act 3 clk after the pin changes.
// No backpressure: the SPI master owns timing; CS high aborts the frame at any point.
module spi_memory_burst #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int BURST_EN   = 1,
    parameter int LED_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk_pin,
    input  logic                 cs_pin,
    input  logic                 mosi_pin,
    output logic                 miso_pin,
    output logic                 miso_oe,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 frame_active,
    output logic                 word_done
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_RW, READ_LOAD, READ, WRITE, WRITE_COMMIT, DONE
    } state_t;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q, mosi_dly_q;

    // CS synchroniser resets high so leaving reset never looks like a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            mosi_dly_q  <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_pin;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_pin;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= mosi_pin;
            mosi_sync_q <= mosi_meta_q;
            mosi_dly_q  <= mosi_sync_q;
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   = cs_prev_q & ~cs_sync_q;
    assign cs_rise   = ~cs_prev_q & cs_sync_q;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q & ~cs_sync_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q & ~cs_sync_q;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic [LED_WIDTH-1:0]   leds_q, leds_d;
    logic                   fa_q, fa_d;
    logic                   wd_q, wd_d;
    logic                   mem_we;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_idx, addr_inc;

    assign addr_idx = ADDR_WIDTH'(32'(addr_q) % DEPTH);
    assign addr_inc = (32'(addr_idx) == DEPTH - 1) ? '0 : addr_idx + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        leds_d  = leds_q;
        fa_d    = fa_q;
        wd_d    = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: ;
            GET_ADDR: begin
                if (sclk_rise) begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], mosi_dly_q};
                    if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = GET_RW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GET_RW: begin
                if (sclk_rise) begin
                    cnt_d   = '0;
                    state_d = mosi_dly_q ? READ_LOAD : WRITE;
                end
            end
            READ_LOAD: begin
                shift_d = mem[addr_idx];
                word_d  = mem[addr_idx];
                oe_d    = 1'b1;
                state_d = READ;
            end
            READ: begin
                if (sclk_fall) begin
                    miso_d  = shift_q[DATA_WIDTH-1];
                    shift_d = shift_q << 1;
                end
                if (sclk_rise) begin
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        cnt_d  = '0;
                        wd_d   = 1'b1;
                        leds_d = word_q[LED_WIDTH-1:0];
                        if (BURST_EN != 0) begin
                            addr_d  = addr_inc;
                            state_d = READ_LOAD;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_dly_q};
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = WRITE_COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE_COMMIT: begin
                // A fully received word commits even if CS rises in this same cycle.
                mem_we = 1'b1;
                wd_d   = 1'b1;
                leds_d = shift_q[LED_WIDTH-1:0];
                if (BURST_EN != 0) begin
                    addr_d  = addr_inc;
                    state_d = WRITE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: oe_d = 1'b0;
            default: state_d = IDLE;
        endcase

        if (cs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            fa_d    = 1'b0;
            miso_d  = 1'b0;
            cnt_d   = '0;
        end
        if (cs_fall) begin
            state_d = GET_ADDR;
            addr_d  = '0;
            cnt_d   = '0;
            shift_d = '0;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            fa_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            leds_q  <= '0;
            fa_q    <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            leds_q  <= leds_d;
            fa_q    <= fa_d;
            wd_q    <= wd_d;
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_idx] <= shift_q;
    end

    assign miso_pin     = miso_q;
    assign miso_oe      = oe_q;
    assign leds         = leds_q;
    assign frame_active = fa_q;
    assign word_done    = wd_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench: a burst-enabled and a single-word instance share the SPI pins.
module tb_spi_memory_burst;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk_pin = 1'b0;
    logic cs_pin = 1'b1;
    logic mosi_pin = 1'b0;

    logic       miso1, oe1, fa1, wd1;
    logic [3:0] leds1;
    logic       miso2, oe2, fa2, wd2;
    logic [3:0] leds2;

    int checks = 0;
    int errors = 0;
    int wd1_cnt = 0;
    int wd2_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wd1) wd1_cnt++;
        if (wd2) wd2_cnt++;
    end

    spi_memory_burst #(.BURST_EN(1)) dut_burst (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso1), .miso_oe(oe1), .leds(leds1),
        .frame_active(fa1), .word_done(wd1)
    );

    spi_memory_burst #(.BURST_EN(0)) dut_single (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso2), .miso_oe(oe2), .leds(leds2),
        .frame_active(fa2), .word_done(wd2)
    );

    // One SCLK period (5 clk low, 5 clk high); MISO is sampled just before the rising edge.
    task automatic send_bit(input logic b, output logic m1, output logic m2,
                            output logic o1, output logic o2);
        mosi_pin = b;
        #50;
        m1 = miso1; m2 = miso2; o1 = oe1; o2 = oe2;
        sclk_pin = 1'b1;
        #50;
        sclk_pin = 1'b0;
    endtask

    task automatic do_frame(input logic [6:0] addr, input logic rw, input int nbits,
                            input logic [15:0] data,
                            output logic [15:0] r1, output logic [15:0] r2,
                            output int oc1, output int oc2, output logic fa_mid);
        logic m1, m2, o1, o2;
        r1 = '0; r2 = '0; oc1 = 0; oc2 = 0;
        cs_pin = 1'b0;
        #50;
        for (int i = 6; i >= 0; i--) send_bit(addr[i], m1, m2, o1, o2);
        send_bit(rw, m1, m2, o1, o2);
        fa_mid = fa1;
        for (int i = 0; i < nbits; i++) begin
            send_bit(data[nbits-1-i], m1, m2, o1, o2);
            r1 = {r1[14:0], m1};
            r2 = {r2[14:0], m2};
            if (o1) oc1++;
            if (o2) oc2++;
        end
        #50;
        cs_pin = 1'b1;
        #60;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #20;
        checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso1); end
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oe1); end
        checks++; if (leds1 !== 4'h0) begin errors++; $display("FAIL reset_leds got %h want 0", leds1); end
        checks++; if (fa1 !== 1'b0) begin errors++; $display("FAIL reset_frame_active got %b want 0", fa1); end
        checks++; if (wd1 !== 1'b0) begin errors++; $display("FAIL reset_word_done got %b want 0", wd1); end
        reset_n = 1'b1;
        #20;
    endtask

    task automatic test_single_write;
        logic [15:0] r1, r2; int oc1, oc2; logic fam; int w0;
        w0 = wd1_cnt;
        do_frame(7'h2A, 1'b0, 8, 16'h0007, r1, r2, oc1, oc2, fam);
        checks++; if (fam !== 1'b1) begin errors++; $display("FAIL wr_frame_active_mid got %b want 1", fam); end
        checks++; if (wd1_cnt - w0 !== 1) begin errors++; $display("FAIL wr_word_done got %0d want 1", wd1_cnt - w0); end
        checks++; if (leds1 !== 4'h7) begin errors++; $display("FAIL wr_leds got %h want 7", leds1); end
        checks++; if (oc1 !== 0) begin errors++; $display("FAIL wr_oe_samples got %0d want 0", oc1); end
        checks++; if (fa1 !== 1'b0) begin errors++; $display("FAIL wr_frame_active_end got %b want 0", fa1); end
    endtask

    task automatic test_single_read;
        logic [15:0] r1, r2; int oc1, oc2; logic fam; int w0;
        w0 = wd1_cnt;
        do_frame(7'h2A, 1'b1, 8, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r1[7:0] !== 8'h07) begin errors++; $display("FAIL rd_data got %h want 07", r1[7:0]); end
        checks++; if (oc1 !== 8) begin errors++; $display("FAIL rd_oe_samples got %0d want 8", oc1); end
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL rd_oe_after_cs got %b want 0", oe1); end
        checks++; if (leds1 !== 4'h7) begin errors++; $display("FAIL rd_leds got %h want 7", leds1); end
        checks++; if (wd1_cnt - w0 !== 1) begin errors++; $display("FAIL rd_word_done got %0d want 1", wd1_cnt - w0); end
    endtask

    task automatic test_burst_wrap;
        logic [15:0] r1, r2; int oc1, oc2; logic fam; int w0;
        w0 = wd1_cnt;
        do_frame(7'h7F, 1'b0, 16, 16'hA53C, r1, r2, oc1, oc2, fam);
        checks++; if (wd1_cnt - w0 !== 2) begin errors++; $display("FAIL bw_word_done got %0d want 2", wd1_cnt - w0); end
        checks++; if (leds1 !== 4'hC) begin errors++; $display("FAIL bw_leds got %h want c", leds1); end
        do_frame(7'h7F, 1'b1, 16, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r1 !== 16'hA53C) begin errors++; $display("FAIL br_data got %h want a53c", r1); end
        checks++; if (oc1 !== 16) begin errors++; $display("FAIL br_oe_samples got %0d want 16", oc1); end
        do_frame(7'h00, 1'b1, 8, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r1[7:0] !== 8'h3C) begin errors++; $display("FAIL br_mem0 got %h want 3c", r1[7:0]); end
    endtask

    task automatic test_abort;
        logic [15:0] r1, r2; int oc1, oc2; logic fam; int w0;
        do_frame(7'h10, 1'b0, 8, 16'h0055, r1, r2, oc1, oc2, fam);
        w0 = wd1_cnt;
        do_frame(7'h10, 1'b0, 5, 16'h001A, r1, r2, oc1, oc2, fam);
        checks++; if (wd1_cnt - w0 !== 0) begin errors++; $display("FAIL ab_word_done got %0d want 0", wd1_cnt - w0); end
        checks++; if (fa1 !== 1'b0) begin errors++; $display("FAIL ab_frame_active got %b want 0", fa1); end
        checks++; if (leds1 !== 4'h5) begin errors++; $display("FAIL ab_leds got %h want 5", leds1); end
        do_frame(7'h10, 1'b1, 8, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r1[7:0] !== 8'h55) begin errors++; $display("FAIL ab_mem16 got %h want 55", r1[7:0]); end
    endtask

    task automatic test_no_burst;
        logic [15:0] r1, r2; int oc1, oc2; logic fam; int w1, w2;
        do_frame(7'h05, 1'b0, 8, 16'h009E, r1, r2, oc1, oc2, fam);
        w1 = wd1_cnt; w2 = wd2_cnt;
        do_frame(7'h05, 1'b1, 16, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r2[15:8] !== 8'h9E) begin errors++; $display("FAIL nb_data got %h want 9e", r2[15:8]); end
        checks++; if (oc2 !== 8) begin errors++; $display("FAIL nb_oe_samples got %0d want 8", oc2); end
        checks++; if (wd2_cnt - w2 !== 1) begin errors++; $display("FAIL nb_word_done got %0d want 1", wd2_cnt - w2); end
        checks++; if (leds2 !== 4'hE) begin errors++; $display("FAIL nb_leds got %h want e", leds2); end
        checks++; if (wd1_cnt - w1 !== 2) begin errors++; $display("FAIL nb_burst_ref_word_done got %0d want 2", wd1_cnt - w1); end
        checks++; if (r1[15:8] !== 8'h9E) begin errors++; $display("FAIL nb_burst_ref_data got %h want 9e", r1[15:8]); end
    endtask

    task automatic test_reset_mid_frame;
        logic m1, m2, o1, o2;
        logic [15:0] r1, r2; int oc1, oc2; logic fam;
        logic [6:0] a;
        a = 7'h2A;
        cs_pin = 1'b0;
        #50;
        for (int i = 6; i >= 0; i--) send_bit(a[i], m1, m2, o1, o2);
        send_bit(1'b1, m1, m2, o1, o2);
        for (int i = 0; i < 3; i++) send_bit(1'b0, m1, m2, o1, o2);
        checks++; if (oe1 !== 1'b1) begin errors++; $display("FAIL rm_oe_before got %b want 1", oe1); end
        reset_n = 1'b0;
        #1;
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL rm_oe got %b want 0", oe1); end
        checks++; if (fa1 !== 1'b0) begin errors++; $display("FAIL rm_frame_active got %b want 0", fa1); end
        checks++; if (leds1 !== 4'h0) begin errors++; $display("FAIL rm_leds got %h want 0", leds1); end
        checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL rm_miso got %b want 0", miso1); end
        #9;
        cs_pin = 1'b1;
        #20;
        reset_n = 1'b1;
        #20;
        do_frame(7'h2A, 1'b1, 8, 16'h0000, r1, r2, oc1, oc2, fam);
        checks++; if (r1[7:0] !== 8'h07) begin errors++; $display("FAIL rm_read_after got %h want 07", r1[7:0]); end
        checks++; if (leds1 !== 4'h7) begin errors++; $display("FAIL rm_leds_after got %h want 7", leds1); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_burst_wrap();
        test_abort();
        test_no_burst();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_memory_burst.md
Name: spi_memory_burst

Overview:
- Parametrised SPI-slave memory; next generation of the single-byte SPI memory.
- Adds configurable address/data width, auto-increment burst transfers within one chip-select frame, input synchronisation, explicit MISO output-enable, mid-frame abort handling and status outputs.
- Sits between the board SPI pins and on-chip storage; runs entirely in the system clock domain.

Parameters:
- ADDR_WIDTH, 7, address bits sent per frame.
- DATA_WIDTH, 8, bits per data word.
- DEPTH, 2**ADDR_WIDTH, number of words; addresses >= DEPTH wrap modulo DEPTH.
- BURST_EN, 1, 1 = auto-increment across words while CS low; 0 = one word per frame, extra clocks ignored.
- LED_WIDTH, 4, width of the status LED bus.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_pin  in  1  SPI clock, asynchronous to clk, mode 0.
- cs_pin  in  1  chip select, active low.
- mosi_pin  in  1  serial data in, MSB first.
- miso_pin  out  1  serial data out, MSB first.
- miso_oe  out  1  high while this slave drives miso_pin.
- leds  out  LED_WIDTH  low LED_WIDTH bits of the last completed word, read or write.
- frame_active  out  1  high while a frame is in progress.
- word_done  out  1  one-clk pulse per completed data word.

Behaviour:
- Reset: miso_pin=0, miso_oe=0, leds=0, frame_active=0, word_done=0; FSM to IDLE; address, counter and shift registers cleared. Memory array is not reset.
- Inputs: sclk_pin, cs_pin and mosi_pin each pass a 2-FF synchroniser plus one edge-detect FF. An SPI edge is acted on 3 clk cycles after the pin changes. SCLK high and low phases are each >= 4 clk.
- Frame: CS falling edge -> GET_ADDR, frame_active=1, bit counter=0.
- GET_ADDR: each sync'd SCLK rising edge shifts mosi into the address register, MSB first. After ADDR_WIDTH bits -> GET_RW.
- GET_RW: next rising edge samples R/W (1=read, 0=write).
  - Read: next clk, shift register <= mem[addr], state READ, miso_oe=1.
  - Write: state WRITE.
- READ:
  - Each sync'd SCLK falling edge drives miso_pin = shift register MSB, then shifts left. The first word's MSB is presented on the falling edge following the R/W rising edge.
  - Rising edges count bits. On the DATA_WIDTH-th rising edge: word_done pulses, leds update.
  - If BURST_EN: addr <= addr+1 mod DEPTH, and next clk reloads the shift register so the next word's MSB appears on the next falling edge.
  - If not BURST_EN: -> DONE.
- WRITE:
  - Each rising edge shifts mosi in.
  - On the DATA_WIDTH-th bit: next clk mem[addr] <= word, word_done pulses, leds update.
  - If BURST_EN: addr increments with wrap, counter clears, stay in WRITE. Else -> DONE.
- DONE: ignore SCLK; miso_oe=0; wait for CS high.
- CS rising edge in any state -> IDLE within 1 clk of the sync'd edge: miso_oe=0, frame_active=0.
  - A partial write word is discarded; memory is not modified.
  - A partial address or R/W leaves no side effects.
- SCLK edges while CS is high are ignored. CS falling and SCLK rising detected in the same clk: the CS edge wins, and that SCLK edge is ignored.
- Write then read of the same address in consecutive frames returns the new data; the write commits before the frame ends.
- Burst address wrap: DEPTH-1 -> 0.
- FSM states: IDLE, GET_ADDR, GET_RW, READ_LOAD, READ, WRITE, WRITE_COMMIT, DONE.

Test Plan:
- Single write: addr 7'h2A, W, data 8'h07, CS high -> mem[42]=8'h07, one word_done pulse, leds=4'h7, miso_oe stays 0.
- Single read: addr 7'h2A, R, 8 clocks -> miso shifts 0,0,0,0,0,1,1,1; miso_oe=1 during data, 0 after CS high; leds=4'h7.
- Burst write with wrap: addr 7'h7F, W, words 8'hA5, 8'h3C -> mem[127]=8'hA5, mem[0]=8'h3C, two word_done pulses; burst read of addr 7'h7F returns A5 then 3C.
- Abort: addr 7'h10, W, 5 data bits, CS high -> mem[16] unchanged (prewritten 8'h55 still reads 8'h55); FSM IDLE, frame_active=0.
- BURST_EN=0: addr 7'h05, R, 16 clocks -> first 8 bits = mem[5], miso_oe drops after word 1, single word_done.
- Reset mid-frame: reset_n low during READ -> all outputs 0 immediately; the next full frame behaves normally.
